// File: rtl/spi_eeprom_pkg.sv
// Shared opcodes, FSM states and status-register layout for the SPI EEPROM target.
package spi_eeprom_pkg;

   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_WRITE = 8'h02;
   localparam logic [7:0] OP_WREN  = 8'h06;
   localparam logic [7:0] OP_WRDI  = 8'h04;
   localparam logic [7:0] OP_RDSR  = 8'h05;

   localparam int SR_WEL = 1;
   localparam int SR_WIP = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_RD,
      ST_WR,
      ST_STAT,
      ST_IGNORE
   } state_e;

   // Writes never stall this model, so WIP always reads back as 0.
   function automatic logic [7:0] statusByte(input logic welBit);
      logic [7:0] sr;
      sr         = 8'h00;
      sr[SR_WEL] = welBit;
      sr[SR_WIP] = 1'b0;
      return sr;
   endfunction

endpackage

// File: rtl/spi_eeprom_target_sync.sv
// Two-flop synchronizer for an asynchronous pin, plus registered rise/fall pulses
// aligned with the delayed level output.
module spi_sync_edge #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;
   logic rise_q;
   logic fall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
         prev_q <= RESET_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
         rise_q <= sync_q & ~prev_q;
         fall_q <= ~sync_q & prev_q;
      end
   end

   assign level_o = prev_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/spi_eeprom_target.sv
// Mode-0 SPI target emulating a small 25xx serial EEPROM (READ/WRITE/WREN/WRDI/RDSR),
// with every SPI pin oversampled by the system clock.
module spi_eeprom_target
   import spi_eeprom_pkg::*;
#(
   parameter int MEM_BYTES = 128,
   parameter int ADDR_W    = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_cs_n,
   input  logic              spi_sclk,
   input  logic              spi_mosi,
   output logic              spi_miso,
   input  logic              pre_we,
   input  logic [ADDR_W-1:0] pre_addr,
   input  logic [7:0]        pre_wdata,
   output logic              busy,
   output logic              wel
);

   logic csLevel, csRise, csFall;
   logic sclkLevel, sclkRise, sclkFall;
   logic mosiLevel, mosiRise, mosiFall;
   logic unusedSync;

   spi_sync_edge #(.RESET_VAL(1'b1)) uCsSync (
      .clk(clk), .rst_n(rst_n), .d_i(spi_cs_n),
      .level_o(csLevel), .rise_o(csRise), .fall_o(csFall)
   );

   spi_sync_edge #(.RESET_VAL(1'b0)) uSclkSync (
      .clk(clk), .rst_n(rst_n), .d_i(spi_sclk),
      .level_o(sclkLevel), .rise_o(sclkRise), .fall_o(sclkFall)
   );

   spi_sync_edge #(.RESET_VAL(1'b0)) uMosiSync (
      .clk(clk), .rst_n(rst_n), .d_i(spi_mosi),
      .level_o(mosiLevel), .rise_o(mosiRise), .fall_o(mosiFall)
   );

   assign unusedSync = ^{sclkLevel, mosiRise, mosiFall};

   state_e            state_q, state_d;
   logic [2:0]        bitCnt_q, bitCnt_d;
   logic [7:0]        rxSh_q, rxSh_d;
   logic [7:0]        txSh_q, txSh_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wel_q, wel_d;
   logic              isRead_q, isRead_d;
   logic              wrCmd_q, wrCmd_d;
   logic [7:0]        rxNext;
   logic              memWe;
   logic [7:0]        mem_q [MEM_BYTES];

   always_comb begin
      state_d  = state_q;
      bitCnt_d = bitCnt_q;
      rxSh_d   = rxSh_q;
      txSh_d   = txSh_q;
      addr_d   = addr_q;
      wel_d    = wel_q;
      isRead_d = isRead_q;
      wrCmd_d  = wrCmd_q;
      memWe    = 1'b0;
      rxNext   = {rxSh_q[6:0], mosiLevel};

      // Deselect discards any partial byte; only a completed WRITE command clears WEL.
      if (csRise) begin
         state_d  = ST_IDLE;
         bitCnt_d = 3'd0;
         txSh_d   = 8'h00;
         wrCmd_d  = 1'b0;
         if (wrCmd_q) wel_d = 1'b0;
      end else if (csFall) begin
         state_d  = ST_CMD;
         bitCnt_d = 3'd0;
         rxSh_d   = 8'h00;
         txSh_d   = 8'h00;
         wrCmd_d  = 1'b0;
      end else if (state_q != ST_IDLE) begin
         if (sclkRise) begin
            rxSh_d   = rxNext;
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
               txSh_d = 8'h00;
               case (state_q)
                  ST_CMD: begin
                     case (rxNext)
                        OP_READ: begin
                           state_d  = ST_ADDR;
                           isRead_d = 1'b1;
                        end
                        OP_WRITE: begin
                           state_d  = ST_ADDR;
                           isRead_d = 1'b0;
                           wrCmd_d  = 1'b1;
                        end
                        OP_WREN: begin
                           wel_d   = 1'b1;
                           state_d = ST_IGNORE;
                        end
                        OP_WRDI: begin
                           wel_d   = 1'b0;
                           state_d = ST_IGNORE;
                        end
                        OP_RDSR: begin
                           state_d = ST_STAT;
                           txSh_d  = statusByte(wel_q);
                        end
                        default: state_d = ST_IGNORE;
                     endcase
                  end
                  ST_ADDR: begin
                     addr_d = rxNext[ADDR_W-1:0];
                     if (isRead_q) begin
                        txSh_d  = mem_q[rxNext[ADDR_W-1:0]];
                        addr_d  = rxNext[ADDR_W-1:0] + ADDR_W'(1);
                        state_d = ST_RD;
                     end else begin
                        state_d = ST_WR;
                     end
                  end
                  ST_RD: begin
                     txSh_d = mem_q[addr_q];
                     addr_d = addr_q + ADDR_W'(1);
                  end
                  ST_WR: begin
                     memWe  = wel_q;
                     addr_d = addr_q + ADDR_W'(1);
                  end
                  ST_STAT: txSh_d = statusByte(wel_q);
                  default: ;
               endcase
            end
         end else if (sclkFall && (bitCnt_q != 3'd0)) begin
            txSh_d = {txSh_q[6:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         bitCnt_q <= 3'd0;
         rxSh_q   <= 8'h00;
         txSh_q   <= 8'h00;
         addr_q   <= '0;
         wel_q    <= 1'b0;
         isRead_q <= 1'b0;
         wrCmd_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         bitCnt_q <= bitCnt_d;
         rxSh_q   <= rxSh_d;
         txSh_q   <= txSh_d;
         addr_q   <= addr_d;
         wel_q    <= wel_d;
         isRead_q <= isRead_d;
         wrCmd_q  <= wrCmd_d;
      end
   end

   // Backdoor preload only lands while the bus is idle.
   always_ff @(posedge clk) begin
      if (memWe) begin
         mem_q[addr_q] <= rxNext;
      end else if (pre_we && !busy) begin
         mem_q[pre_addr] <= pre_wdata;
      end
   end

   assign spi_miso = txSh_q[7];
   assign busy     = ~csLevel;
   assign wel      = wel_q;

endmodule

// File: tb/tb_spi_eeprom_target.sv
// Self-checking bench for spi_eeprom_target: table-driven frames, hand-written corner
// sequences, then random frames compared against a frame-level EEPROM model.
module tb_spi_eeprom_target;

   localparam int MEM  = 128;
   localparam int HALF = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       spi_cs_n;
   logic       spi_sclk;
   logic       spi_mosi;
   logic       spi_miso;
   logic       pre_we;
   logic [6:0] pre_addr;
   logic [7:0] pre_wdata;
   logic       busy;
   logic       wel;

   int checks   = 0;
   int failures = 0;

   logic [7:0] initMem [MEM];
   logic [7:0] refMem  [MEM];
   bit         refWel;
   logic [7:0] txBuf   [16];
   logic [7:0] rxBuf   [16];
   logic [7:0] expBuf  [16];
   logic [127:0] pskWord = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   typedef struct {
      logic [7:0] op;
      logic [7:0] addr;
      logic [7:0] data;
      int         nBytes;
      logic [7:0] expLast;
      logic       expWel;
   } vec_t;

   vec_t vecs [14];

   spi_eeprom_target #(.MEM_BYTES(128), .ADDR_W(7)) dut (
      .clk(clk), .rst_n(rst_n),
      .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
      .pre_we(pre_we), .pre_addr(pre_addr), .pre_wdata(pre_wdata),
      .busy(busy), .wel(wel)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   task automatic spiXfer(input logic [7:0] txByte, output logic [7:0] rxByte);
      for (int i = 7; i >= 0; i--) begin
         spi_mosi = txByte[i];
         repeat (HALF) @(negedge clk);
         rxByte[i] = spi_miso;
         spi_sclk = 1'b1;
         repeat (HALF) @(negedge clk);
         spi_sclk = 1'b0;
      end
   endtask

   task automatic spiBits(input logic [7:0] txByte, input int nBits);
      for (int i = 7; i > 7 - nBits; i--) begin
         spi_mosi = txByte[i];
         repeat (HALF) @(negedge clk);
         spi_sclk = 1'b1;
         repeat (HALF) @(negedge clk);
         spi_sclk = 1'b0;
      end
   endtask

   task automatic csLow();
      spi_cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic csHigh();
      repeat (HALF) @(negedge clk);
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      repeat (2 * HALF) @(negedge clk);
   endtask

   task automatic preload(input logic [6:0] a, input logic [7:0] d);
      pre_addr  = a;
      pre_wdata = d;
      pre_we    = 1'b1;
      @(negedge clk);
      pre_we    = 1'b0;
   endtask

   // Frame-level model: what each returned byte should be, and the effect on memory/WEL.
   task automatic modelPredict(input int n);
      int a;
      for (int i = 0; i < n; i++) expBuf[i] = 8'h00;
      a = (n > 1) ? int'(txBuf[1]) % MEM : 0;
      case (txBuf[0])
         8'h03: for (int i = 2; i < n; i++) expBuf[i] = refMem[(a + i - 2) % MEM];
         8'h02: begin
            if (refWel) for (int i = 2; i < n; i++) refMem[(a + i - 2) % MEM] = txBuf[i];
            refWel = 1'b0;
         end
         8'h06: refWel = 1'b1;
         8'h04: refWel = 1'b0;
         8'h05: for (int i = 1; i < n; i++) expBuf[i] = refWel ? 8'h02 : 8'h00;
         default: ;
      endcase
   endtask

   task automatic frame(input int n);
      modelPredict(n);
      csLow();
      for (int i = 0; i < n; i++) spiXfer(txBuf[i], rxBuf[i]);
      csHigh();
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      txBuf[0] = v.op;
      txBuf[1] = v.addr;
      txBuf[2] = v.data;
      frame(v.nBytes);
      checkOutput($sformatf("vec%0d_miso", idx), rxBuf[v.nBytes - 1], v.expLast);
      checkOutput($sformatf("vec%0d_wel", idx), {7'b0, wel}, {7'b0, v.expWel});
   endtask

   initial begin
      rst_n     = 1'b0;
      spi_cs_n  = 1'b1;
      spi_sclk  = 1'b0;
      spi_mosi  = 1'b0;
      pre_we    = 1'b0;
      pre_addr  = '0;
      pre_wdata = '0;
      refWel    = 1'b0;

      vecs[0]  = '{8'h05, 8'h00, 8'h00, 2, 8'h00, 1'b0};
      vecs[1]  = '{8'h02, 8'h10, 8'hA5, 3, 8'h00, 1'b0};
      vecs[2]  = '{8'h03, 8'h10, 8'h00, 3, 8'h00, 1'b0};
      vecs[3]  = '{8'h06, 8'h00, 8'h00, 1, 8'h00, 1'b1};
      vecs[4]  = '{8'h05, 8'h00, 8'h00, 2, 8'h02, 1'b1};
      vecs[5]  = '{8'h04, 8'h00, 8'h00, 1, 8'h00, 1'b0};
      vecs[6]  = '{8'h05, 8'h00, 8'h00, 2, 8'h00, 1'b0};
      vecs[7]  = '{8'h06, 8'h00, 8'h00, 1, 8'h00, 1'b1};
      vecs[8]  = '{8'h02, 8'h90, 8'hC3, 3, 8'h00, 1'b0};
      vecs[9]  = '{8'h03, 8'h10, 8'h00, 3, 8'hC3, 1'b0};
      vecs[10] = '{8'h03, 8'h0F, 8'h00, 3, 8'h3C, 1'b0};
      vecs[11] = '{8'h03, 8'h85, 8'h00, 3, 8'hAE, 1'b0};
      vecs[12] = '{8'h05, 8'h00, 8'h00, 2, 8'h00, 1'b0};
      vecs[13] = '{8'hFF, 8'h00, 8'h00, 3, 8'h00, 1'b0};

      for (int i = 0; i < MEM; i++) begin
         if (i < 16)      initMem[i] = pskWord[127 - 8 * i -: 8];
         else if (i < 32) initMem[i] = 8'h00;
         else             initMem[i] = 8'($urandom);
      end
      initMem[8'h20] = 8'h11;
      initMem[8'h30] = 8'h5C;

      repeat (4) @(negedge clk);
      checkOutput("reset_miso", {7'b0, spi_miso}, 8'h00);
      checkOutput("reset_busy", {7'b0, busy}, 8'h00);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("idle_wel", {7'b0, wel}, 8'h00);
      checkOutput("idle_busy", {7'b0, busy}, 8'h00);

      for (int i = 0; i < MEM; i++) begin
         preload(7'(i), initMem[i]);
         refMem[i] = initMem[i];
      end

      for (int i = 0; i < 14; i++) applyStimulus(vecs[i], i);

      // PSK read-out across 16 consecutive bytes.
      txBuf[0] = 8'h03;
      txBuf[1] = 8'h00;
      for (int i = 2; i < 18 && i < 16; i++) txBuf[i] = 8'h00;
      frame(16);
      for (int i = 2; i < 16; i++)
         checkOutput($sformatf("psk%0d", i - 2), rxBuf[i], pskWord[127 - 8 * (i - 2) -: 8]);
      txBuf[0] = 8'h03;
      txBuf[1] = 8'h0E;
      txBuf[2] = 8'h00;
      txBuf[3] = 8'h00;
      frame(4);
      checkOutput("psk14", rxBuf[2], 8'h4F);
      checkOutput("psk15", rxBuf[3], 8'h3C);

      // WREN, status, then a write that wraps past the top of memory.
      txBuf[0] = 8'h06;
      frame(1);
      txBuf[0] = 8'h05;
      txBuf[1] = 8'h00;
      frame(2);
      checkOutput("rdsr_after_wren", rxBuf[1], 8'h02);
      txBuf[0] = 8'h02;
      txBuf[1] = 8'h7F;
      txBuf[2] = 8'hA5;
      txBuf[3] = 8'h5A;
      frame(4);
      txBuf[0] = 8'h05;
      txBuf[1] = 8'h00;
      frame(2);
      checkOutput("rdsr_after_write", rxBuf[1], 8'h00);
      txBuf[0] = 8'h03;
      txBuf[1] = 8'h7E;
      for (int i = 2; i < 5; i++) txBuf[i] = 8'h00;
      frame(5);
      checkOutput("wrap_rd_7e", rxBuf[2], initMem[8'h7E]);
      checkOutput("wrap_rd_7f", rxBuf[3], 8'hA5);
      checkOutput("wrap_rd_00", rxBuf[4], 8'h5A);

      // Deselect after only five data bits must not commit the byte.
      txBuf[0] = 8'h06;
      frame(1);
      csLow();
      spiXfer(8'h02, rxBuf[0]);
      spiXfer(8'h20, rxBuf[1]);
      spiBits(8'hFF, 5);
      csHigh();
      refWel = 1'b0;
      checkOutput("partial_wel", {7'b0, wel}, 8'h00);
      txBuf[0] = 8'h03;
      txBuf[1] = 8'h20;
      txBuf[2] = 8'h00;
      frame(3);
      checkOutput("partial_mem20", rxBuf[2], 8'h11);

      txBuf[0] = 8'hFF;
      txBuf[1] = 8'h12;
      txBuf[2] = 8'h34;
      txBuf[3] = 8'h56;
      frame(4);
      for (int i = 0; i < 4; i++) checkOutput($sformatf("badop_b%0d", i), rxBuf[i], 8'h00);

      // Busy follows CS after three clocks; preload is locked out while selected.
      spi_cs_n = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("busy_rise_early", {7'b0, busy}, 8'h00);
      @(negedge clk);
      checkOutput("busy_rise", {7'b0, busy}, 8'h01);
      preload(7'h30, 8'hEE);
      repeat (4) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("busy_fall_early", {7'b0, busy}, 8'h01);
      @(negedge clk);
      checkOutput("busy_fall", {7'b0, busy}, 8'h00);
      repeat (HALF) @(negedge clk);
      txBuf[0] = 8'h03;
      txBuf[1] = 8'h30;
      txBuf[2] = 8'h00;
      frame(3);
      checkOutput("prewe_locked", rxBuf[2], 8'h5C);

      // Reset in the middle of a READ data byte.
      txBuf[0] = 8'h06;
      frame(1);
      csLow();
      spiXfer(8'h03, rxBuf[0]);
      spiXfer(8'h00, rxBuf[1]);
      spiBits(8'h00, 4);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_miso", {7'b0, spi_miso}, 8'h00);
      checkOutput("rst_busy", {7'b0, busy}, 8'h00);
      checkOutput("rst_wel", {7'b0, wel}, 8'h00);
      spi_cs_n = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      refWel = 1'b0;
      repeat (2 * HALF) @(negedge clk);
      txBuf[0] = 8'h03;
      txBuf[1] = 8'h00;
      txBuf[2] = 8'h00;
      frame(3);
      checkOutput("post_rst_mem00", rxBuf[2], 8'h5A);

      // Random frames against the model.
      for (int t = 0; t < 30; t++) begin
         int r;
         int n;
         r = int'($urandom_range(0, 9));
         if (r <= 2)      txBuf[0] = 8'h03;
         else if (r <= 4) txBuf[0] = 8'h02;
         else if (r <= 6) txBuf[0] = 8'h06;
         else if (r == 7) txBuf[0] = 8'h04;
         else if (r == 8) txBuf[0] = 8'h05;
         else             txBuf[0] = 8'($urandom);
         n = (r <= 4) ? 2 + int'($urandom_range(1, 4)) : int'($urandom_range(1, 3));
         for (int i = 1; i < n; i++) txBuf[i] = 8'($urandom);
         frame(n);
         for (int i = 0; i < n; i++)
            checkOutput($sformatf("rnd%0d_op%h_b%0d", t, txBuf[0], i), rxBuf[i], expBuf[i]);
         checkOutput($sformatf("rnd%0d_wel", t), {7'b0, wel}, {7'b0, refWel});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_eeprom_target.md
# spi_eeprom_target

SPI mode-0 target that emulates a small 25xx-style serial EEPROM (READ, WRITE, WREN, WRDI, RDSR) behind the `eeprom_spi_*` pins of `main_core`. It is the responder end of the key-storage link. It is used as the synthesizable EEPROM stand-in for FPGA bring-up and as the bench-side memory model for full-chip PSK-load tests. All SPI inputs are oversampled by the system clock; no logic runs on SCLK.

## Interface
- `MEM_BYTES`, 128: memory depth in bytes; must be a power of two.
- `ADDR_W`, 7: address width, equal to log2(MEM_BYTES) and ≤ 8.
- `clk`  in  1: system clock; SCLK must be ≤ clk/8.
- `rst_n`  in  1: asynchronous, active-low reset.
- `spi_cs_n`  in  1: chip select, active low.
- `spi_sclk`  in  1: SPI clock, mode 0 (CPOL=0, CPHA=0).
- `spi_mosi`  in  1: serial data in, MSB first.
- `spi_miso`  out  1: serial data out, MSB first; driven 0 while deselected (never tri-stated).
- `pre_we`  in  1: backdoor preload write strobe.
- `pre_addr`  in  ADDR_W: preload address.
- `pre_wdata`  in  8: preload data.
- `busy`  out  1: synchronized CS active.
- `wel`  out  1: write-enable latch.

## Operation
- `spi_cs_n`, `spi_sclk` and `spi_mosi` each pass through a 2-FF synchronizer. SCLK rise/fall and CS fall/rise are edge-detected on the synchronized values.
- RX: on each SCLK rise, shift MOSI into `rx_sh` and increment the 3-bit `bit_cnt`. A byte completes on the 8th rise, at which point `bit_cnt` wraps to 0.
- TX: on byte completion, load `tx_sh`; `spi_miso` = `tx_sh[7]`. On an SCLK fall, shift `tx_sh` left only if `bit_cnt` ≠ 0. This skips the fall that immediately follows the load.
- FSM states: IDLE, CMD, ADDR, RD, WR, STAT, IGNORE.
  - IDLE→CMD on CS fall.
  - From CMD, on byte completion:
    - 0x03 → ADDR, then RD.
    - 0x02 → ADDR, then WR.
    - 0x06 sets `wel` → IGNORE.
    - 0x04 clears `wel` → IGNORE.
    - 0x05 → STAT; `tx_sh` = {6'b0, wel, 1'b0}.
    - Any other opcode → IGNORE.
  - ADDR: on byte completion, `addr` = `rx_sh[ADDR_W-1:0]` (upper bits ignored).
    - For RD, load `tx_sh` = `mem[addr]`, then `addr`++.
  - RD: on each byte completion, load `tx_sh` = `mem[addr]`, then `addr`++.
  - WR: on each byte completion, if `wel`=1, `mem[addr]` = `rx_sh`; `addr`++ regardless.
  - STAT: the status byte is reloaded on every byte completion.
  - Any state → IDLE on CS rise. If the command was 0x02, clear `wel`, regardless of whether any data was written.
- Address increment wraps modulo MEM_BYTES: 0x7F→0x00.
- A partial byte at CS rise is discarded and never written.
- Preload: `pre_we` writes `mem[pre_addr]` only when `busy`=0; it is ignored while selected.
- Memory array is not reset.

## Timing
- Reset values: `spi_miso`=0, `busy`=0, `wel`=0, FSM=IDLE, `bit_cnt`=0, `tx_sh`=0, synchronizers=1 for CS and 0 for SCLK/MOSI.
- Pin-to-action latency: 3 clk (2 sync + 1 edge register) from any pin edge.
- `spi_miso` is valid ≤ 4 clk after the triggering SCLK fall or byte-completing rise. It therefore meets the master's next rise when SCLK ≤ clk/8.
- `busy` rises/falls 3 clk after the CS pin edge.
- Memory write commits on the clk that registers the 8th rise.
- Reset mid-transaction: immediate return to IDLE. Any following SCLK activity is ignored until a fresh CS fall.

## Structure
- `spi_eeprom_pkg` holds:
  - Opcode constants: OP_READ 0x03, OP_WRITE 0x02, OP_WREN 0x06, OP_WRDI 0x04, OP_RDSR 0x05.
  - FSM state enum.
  - Status bit positions: WEL=1, WIP=0.
- Sub-module `spi_sync_edge`: 2-FF synchronizer with registered rise/fall pulse outputs. Instantiated once each for SCLK, CS and MOSI; rise/fall outputs are left unused on MOSI.
- Expected size: ~200 lines of RTL.

## Test plan
- Preload PSK 0x2b7e151628aed2a6abf7158809cf4f3c at 0x00–0x0F. Send READ 0x03, addr 0x00, 16 dummy bytes → MISO returns 2b 7e 15 16 … 4f 3c.
- WRITE 0x02, addr 0x10, data 0xA5 without a prior WREN → READ of 0x10 returns 0x00; `wel` stays 0.
- WREN, CS cycle, then RDSR → 0x02. Then WRITE addr 0x7F, data A5 5A → `mem[0x7F]`=A5 and `mem[0x00]`=5A (wrap). After the write CS rise, RDSR → 0x00.
- READ starting at 0x7E for 3 bytes → mem[7E], mem[7F], mem[00].
- WREN, then WRITE addr 0x20 with CS raised after 5 data bits → `mem[0x20]` unchanged. Opcode 0xFF → MISO stays 0 for the whole frame.
- Assert `rst_n` low mid-READ → `spi_miso`=0, `busy`=0, `wel`=0. A `pre_we` while CS is low → memory unchanged.
